trdb_packet_scheduler: RTL and testbench
========================================

TRDB_PACKET_SCHEDULER -- requirements
Module: trdb_packet_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, giving the request-queue depth; it must be a power of 2 and at least 2.
REQ-002 SHALL have parameter RESYNC_MAX, default 16'd1024, giving the resync threshold in cycles (16 bits).
REQ-003 SHALL use one clock, clk_i, with asynchronous active-low reset rst_ni.
REQ-004 SHALL have the following ports, listed as name, direction, width, meaning:
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- req_valid_i, in, 1: packet request from the packet-format selector.
- req_format_i, in, trdb_format_e: requested format.
- req_subformat_i, in, trdb_f_sync_subformat_e: requested sync subformat.
- req_ctrl_i, in, 3: {thaddr, cause_mux, tval_mux}.
- resync_rst_i, in, 1: resync counter clear.
- trace_en_i, in, 1: encoder enabled; the resync counter runs only while this is high.
- flush_i, in, 1: synchronous queue flush.
- pkt_valid_o, out, 1: head entry valid toward the packet emitter.
- pkt_ready_i, in, 1: packet emitter accepts the head entry.
- pkt_format_o, out, trdb_format_e: head entry format.
- pkt_subformat_o, out, trdb_f_sync_subformat_e: head entry subformat.
- pkt_ctrl_o, out, 3: head entry control bits.
- max_resync_o, out, 1: resync threshold reached.
- packets_lost_o, out, 1: one or more requests were dropped.
- fifo_full_o, out, 1: queue full.
- fifo_empty_o, out, 1: queue empty.

Function
REQ-005 SHALL store {format, subformat, ctrl} in a FIFO_DEPTH-entry circular queue, using read/write pointers plus an occupancy count of $clog2(FIFO_DEPTH)+1 bits.
REQ-006 SHALL push when req_valid_i=1 and (not full or pop in the same cycle); the entry becomes visible at the head 1 cycle later.
REQ-007 SHALL pop when pkt_valid_o=1 and pkt_ready_i=1; the outputs then show the next entry in the following cycle.
REQ-008 SHALL drive pkt_valid_o = ~fifo_empty_o, and drive the pkt_* outputs directly from the head register with no combinational path from req_*.
REQ-009 SHALL hold pkt_valid_o and the head data stable while pkt_ready_i=0.
REQ-010 SHALL, on simultaneous push and pop when full, perform both, keep occupancy unchanged, and drop nothing.
REQ-011 SHALL, on simultaneous push and pop when empty, push only; pkt_valid_o rises the next cycle.
REQ-012 SHALL drop the request when req_valid_i=1, the queue is full and there is no pop; queue contents are unchanged.
REQ-013 SHALL wrap pointers modulo FIFO_DEPTH.
REQ-014 SHALL, on flush_i=1, set occupancy and pointers to 0 next cycle, ignoring any push or pop in that cycle; the lost-packet state is unaffected.
REQ-015 SHALL implement resync counter rcnt (16 bits) with next-cycle update rules in this priority order:
- resync_rst_i=1 -> rcnt=0;
- else trace_en_i=1 and rcnt<RESYNC_MAX -> rcnt+1;
- else hold.
REQ-016 SHALL drive max_resync_o = (rcnt == RESYNC_MAX); the counter saturates there with no wrap.
REQ-017 SHALL drive fifo_full_o = (occupancy == FIFO_DEPTH) and fifo_empty_o = (occupancy == 0).

Reset
REQ-018 SHALL, while rst_ni=0, asynchronously clear the queue, pointers, rcnt and lost counter, giving pkt_valid_o=0, fifo_empty_o=1, fifo_full_o=0, max_resync_o=0, packets_lost_o=0, and pkt_format_o/pkt_subformat_o/pkt_ctrl_o = 0.
REQ-019 SHALL discard all pending entries on a reset asserted mid-transfer, with no partial pop.

Configuration
REQ-020 SHALL, with TRDB_PACKETS_LOST_EN defined, keep an 8-bit saturating lost counter as follows:
- increments on each drop (REQ-012);
- packets_lost_o = (count != 0);
- cleared next cycle when a request with format F_SYNC and subformat SF_SUPPORT is pushed;
- if that push coincides with a drop, the count becomes 1.
REQ-021 SHALL, without TRDB_PACKETS_LOST_EN, have no lost counter; packets_lost_o is tied to 0 and drops are silent.

Verification
REQ-022 SHALL be verified by these directed scenarios, each stimulus -> required response:
- Single push of F_DIFF_DELTA with pkt_ready_i=1 -> pkt_valid_o high exactly 1 cycle later for 1 cycle, with matching fields.
- pkt_ready_i=0, then 4 pushes, then a 5th push -> fifo_full_o=1; the 5th is dropped; packets_lost_o=1 (macro on) or 0 (macro off); the 4 entries drain in order once ready goes high.
- Full queue with simultaneous push and pop -> occupancy stays 4; packets_lost_o unchanged.
- Lost count 3, then push F_SYNC/SF_SUPPORT -> packets_lost_o=0 next cycle; the support entry is queued.
- trace_en_i=1 for 1024 cycles -> max_resync_o=1 and stays 1; resync_rst_i pulse -> rcnt=0 and max_resync_o=0 next cycle.
- rst_ni asserted with 3 entries queued -> immediate pkt_valid_o=0; after release the queue is empty and rcnt=0.

Source files
------------

// File: rtl/trdb_packet_scheduler.sv
// Trace packet scheduler: queues packet requests toward the emitter and tracks resync/lost state.
// Optional TRDB_PACKETS_LOST_EN adds an 8-bit saturating lost-request counter.
package trdb_pkg;
  typedef enum logic [1:0] {
    F_OPT_EXT    = 2'd0,
    F_DIFF_DELTA = 2'd1,
    F_ADDR_ONLY  = 2'd2,
    F_SYNC       = 2'd3
  } trdb_format_e;

  typedef enum logic [1:0] {
    SF_START   = 2'd0,
    SF_TRAP    = 2'd1,
    SF_CONTEXT = 2'd2,
    SF_SUPPORT = 2'd3
  } trdb_f_sync_subformat_e;

  typedef struct packed {
    trdb_format_e           format;
    trdb_f_sync_subformat_e subformat;
    logic [2:0]             ctrl;
  } trdb_entry_t;
endpackage

// Purpose: FIFO_DEPTH-entry request queue plus resync counter and lost-request tracking.
// Latency: an accepted request is visible at the head one cycle after the push.
// Backpressure: head holds while pkt_ready_i=0; requests arriving while full without a pop are dropped.
module trdb_packet_scheduler
  import trdb_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RESYNC_MAX = 16'd1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  input  trdb_format_e           req_format_i,
  input  trdb_f_sync_subformat_e req_subformat_i,
  input  logic [2:0]             req_ctrl_i,
  input  logic                   resync_rst_i,
  input  logic                   trace_en_i,
  input  logic                   flush_i,
  output logic                   pkt_valid_o,
  input  logic                   pkt_ready_i,
  output trdb_format_e           pkt_format_o,
  output trdb_f_sync_subformat_e pkt_subformat_o,
  output logic [2:0]             pkt_ctrl_o,
  output logic                   max_resync_o,
  output logic                   packets_lost_o,
  output logic                   fifo_full_o,
  output logic                   fifo_empty_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  trdb_entry_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [15:0]            rcnt_q, rcnt_d;
  trdb_entry_t            req_entry;
  trdb_entry_t            head;
  logic                   push;
  logic                   pop;

  assign req_entry = '{format: req_format_i, subformat: req_subformat_i, ctrl: req_ctrl_i};

  assign fifo_full_o  = (count_q == FULL_CNT);
  assign fifo_empty_o = (count_q == '0);
  assign pkt_valid_o  = ~fifo_empty_o;

  assign pop  = pkt_valid_o & pkt_ready_i;
  assign push = req_valid_i & (~fifo_full_o | pop);

  // Outputs come straight from storage, so nothing on req_* reaches pkt_* in the same cycle.
  assign head            = mem_q[rd_ptr_q];
  assign pkt_format_o    = head.format;
  assign pkt_subformat_o = head.subformat;
  assign pkt_ctrl_o      = head.ctrl;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !flush_i) begin
      mem_q[wr_ptr_q] <= req_entry;
    end
  end

  always_comb begin
    rcnt_d = rcnt_q;
    if (resync_rst_i) begin
      rcnt_d = '0;
    end else if (trace_en_i && (rcnt_q < RESYNC_MAX)) begin
      rcnt_d = rcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rcnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
    end
  end

  assign max_resync_o = (rcnt_q == RESYNC_MAX);

`ifdef TRDB_PACKETS_LOST_EN
  logic [7:0] lost_q, lost_d;
  logic       drop;
  logic       sync_clear;

  assign drop       = req_valid_i & fifo_full_o & ~pop;
  // A support packet that actually enters the queue tells the decoder the loss was reported.
  assign sync_clear = push & ~flush_i & (req_format_i == F_SYNC) & (req_subformat_i == SF_SUPPORT);

  always_comb begin
    lost_d = lost_q;
    if (sync_clear) begin
      lost_d = drop ? 8'd1 : 8'd0;
    end else if (drop && (lost_q != 8'hFF)) begin
      lost_d = lost_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lost_q <= '0;
    end else begin
      lost_q <= lost_d;
    end
  end

  assign packets_lost_o = (lost_q != 8'd0);
`else
  assign packets_lost_o = 1'b0;
`endif

endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// Directed bench for trdb_packet_scheduler: scoreboard of queued entries plus flag checks.
module tb_trdb_packet_scheduler;
  import trdb_pkg::*;

`ifdef TRDB_PACKETS_LOST_EN
  localparam logic LOST_ON = 1'b1;
`else
  localparam logic LOST_ON = 1'b0;
`endif

  logic                   clk_i;
  logic                   rst_ni;
  logic                   req_valid_i;
  trdb_format_e           req_format_i;
  trdb_f_sync_subformat_e req_subformat_i;
  logic [2:0]             req_ctrl_i;
  logic                   resync_rst_i;
  logic                   trace_en_i;
  logic                   flush_i;
  logic                   pkt_valid_o;
  logic                   pkt_ready_i;
  trdb_format_e           pkt_format_o;
  trdb_f_sync_subformat_e pkt_subformat_o;
  logic [2:0]             pkt_ctrl_o;
  logic                   max_resync_o;
  logic                   packets_lost_o;
  logic                   fifo_full_o;
  logic                   fifo_empty_o;

  int checks = 0;
  int errors = 0;
  trdb_entry_t exp_q[$];
  trdb_entry_t fill_tab[4];

  trdb_packet_scheduler dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_format_i    (req_format_i),
    .req_subformat_i (req_subformat_i),
    .req_ctrl_i      (req_ctrl_i),
    .resync_rst_i    (resync_rst_i),
    .trace_en_i      (trace_en_i),
    .flush_i         (flush_i),
    .pkt_valid_o     (pkt_valid_o),
    .pkt_ready_i     (pkt_ready_i),
    .pkt_format_o    (pkt_format_o),
    .pkt_subformat_o (pkt_subformat_o),
    .pkt_ctrl_o      (pkt_ctrl_o),
    .max_resync_o    (max_resync_o),
    .packets_lost_o  (packets_lost_o),
    .fifo_full_o     (fifo_full_o),
    .fifo_empty_o    (fifo_empty_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_req(input trdb_entry_t e, input bit accept);
    req_format_i    = e.format;
    req_subformat_i = e.subformat;
    req_ctrl_i      = e.ctrl;
    req_valid_i     = 1'b1;
    if (accept) exp_q.push_back(e);
    tick();
    req_valid_i = 1'b0;
  endtask

  // Every handshake seen by the emitter must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (rst_ni && pkt_valid_o && pkt_ready_i && !flush_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got entry %0h, expected none", {pkt_format_o, pkt_subformat_o, pkt_ctrl_o});
      end else begin
        chk("sb_entry", {pkt_format_o, pkt_subformat_o, pkt_ctrl_o}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    fill_tab[0] = '{F_DIFF_DELTA, SF_START,   3'd1};
    fill_tab[1] = '{F_ADDR_ONLY,  SF_TRAP,    3'd2};
    fill_tab[2] = '{F_SYNC,       SF_START,   3'd3};
    fill_tab[3] = '{F_OPT_EXT,    SF_CONTEXT, 3'd4};

    rst_ni = 1'b0; req_valid_i = 1'b0; req_format_i = F_OPT_EXT; req_subformat_i = SF_START;
    req_ctrl_i = 3'd0; resync_rst_i = 1'b0; trace_en_i = 1'b0; flush_i = 1'b0; pkt_ready_i = 1'b0;
    #2;
    chk("rst_valid", pkt_valid_o, 0);
    chk("rst_empty", fifo_empty_o, 1);
    chk("rst_full", fifo_full_o, 0);
    chk("rst_max", max_resync_o, 0);
    chk("rst_lost", packets_lost_o, 0);
    chk("rst_fields", {pkt_format_o, pkt_subformat_o, pkt_ctrl_o}, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();

    // Single push with emitter ready: valid for exactly one cycle.
    pkt_ready_i = 1'b1;
    chk("lat_pre", pkt_valid_o, 0);
    push_req('{F_DIFF_DELTA, SF_START, 3'b101}, 1'b1);
    chk("lat_valid", pkt_valid_o, 1);
    chk("lat_fields", {pkt_format_o, pkt_subformat_o, pkt_ctrl_o}, {F_DIFF_DELTA, SF_START, 3'b101});
    tick();
    chk("lat_one_cycle", pkt_valid_o, 0);

    // Fill with emitter stalled, then overflow.
    pkt_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_req(fill_tab[i], 1'b1);
    chk("fill_full", fifo_full_o, 1);
    chk("fill_lost_pre", packets_lost_o, 0);
    push_req('{F_SYNC, SF_TRAP, 3'd7}, 1'b0);
    chk("drop_full", fifo_full_o, 1);
    chk("drop_lost", packets_lost_o, LOST_ON);
    chk("hold_valid", pkt_valid_o, 1);
    chk("hold_head", {pkt_format_o, pkt_subformat_o, pkt_ctrl_o}, fill_tab[0]);

    // Full with simultaneous push and pop.
    pkt_ready_i = 1'b1;
    push_req('{F_ADDR_ONLY, SF_CONTEXT, 3'd6}, 1'b1);
    pkt_ready_i = 1'b0;
    chk("fullpp_full", fifo_full_o, 1);
    chk("fullpp_lost", packets_lost_o, LOST_ON);
    chk("fullpp_head", {pkt_format_o, pkt_subformat_o, pkt_ctrl_o}, fill_tab[1]);

    // Two more drops, then a support packet clears the loss.
    push_req('{F_DIFF_DELTA, SF_TRAP, 3'd0}, 1'b0);
    push_req('{F_DIFF_DELTA, SF_TRAP, 3'd0}, 1'b0);
    chk("lost3", packets_lost_o, LOST_ON);
    pkt_ready_i = 1'b1;
    push_req('{F_SYNC, SF_SUPPORT, 3'b010}, 1'b1);
    pkt_ready_i = 1'b0;
    chk("support_clear", packets_lost_o, 0);
    chk("support_full", fifo_full_o, 1);

    pkt_ready_i = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (fifo_empty_o) break;
      tick();
    end
    chk("drain_empty", fifo_empty_o, 1);
    chk("drain_sb", exp_q.size(), 0);

    // Empty with ready high: push only, valid next cycle.
    push_req('{F_OPT_EXT, SF_TRAP, 3'd5}, 1'b1);
    chk("emptypp_valid", pkt_valid_o, 1);
    tick();
    chk("emptypp_drained", fifo_empty_o, 1);

    // Flush discards entries and the push in the flush cycle.
    pkt_ready_i = 1'b0;
    push_req('{F_ADDR_ONLY, SF_START, 3'd1}, 1'b0);
    push_req('{F_ADDR_ONLY, SF_START, 3'd2}, 1'b0);
    chk("preflush_valid", pkt_valid_o, 1);
    flush_i = 1'b1;
    req_valid_i = 1'b1;
    tick();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    chk("flush_empty", fifo_empty_o, 1);
    chk("flush_valid", pkt_valid_o, 0);
    chk("flush_full", fifo_full_o, 0);
    pkt_ready_i = 1'b1;
    push_req('{F_SYNC, SF_CONTEXT, 3'd3}, 1'b1);
    tick();
    chk("postflush_empty", fifo_empty_o, 1);

    // Resync counter saturation and clear.
    resync_rst_i = 1'b1;
    tick();
    resync_rst_i = 1'b0;
    trace_en_i = 1'b1;
    repeat (1023) tick();
    chk("resync_1023", max_resync_o, 0);
    tick();
    chk("resync_1024", max_resync_o, 1);
    repeat (5) tick();
    chk("resync_sat", max_resync_o, 1);
    resync_rst_i = 1'b1;
    tick();
    resync_rst_i = 1'b0;
    chk("resync_clear", max_resync_o, 0);
    repeat (1024) tick();
    chk("resync_again", max_resync_o, 1);
    trace_en_i = 1'b0;

    // Reset with three entries queued.
    pkt_ready_i = 1'b0;
    push_req('{F_DIFF_DELTA, SF_CONTEXT, 3'd1}, 1'b0);
    push_req('{F_ADDR_ONLY, SF_SUPPORT, 3'd2}, 1'b0);
    push_req('{F_SYNC, SF_TRAP, 3'd3}, 1'b0);
    chk("prerst_valid", pkt_valid_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", pkt_valid_o, 0);
    chk("midrst_empty", fifo_empty_o, 1);
    chk("midrst_max", max_resync_o, 0);
    chk("midrst_fields", {pkt_format_o, pkt_subformat_o, pkt_ctrl_o}, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();
    chk("postrst_empty", fifo_empty_o, 1);
    chk("postrst_valid", pkt_valid_o, 0);
    trace_en_i = 1'b1;
    repeat (1023) tick();
    chk("postrst_rcnt_1023", max_resync_o, 0);
    tick();
    chk("postrst_rcnt_1024", max_resync_o, 1);
    trace_en_i = 1'b0;

    chk("final_sb", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
